ex_muldiv_sequencer: RTL and testbench

- Multi-cycle iterative multiply/divide unit that sits beside the single-cycle ALU in the EX stage.
- Accepts one M-type operation from the EX-stage decode and sequences a 32-iteration shift-add multiply or restoring divide.
- Holds the pipeline with a stall output until the result is ready.
- Owns all sequencing (FSM, iteration counter, handshake); arithmetic is one iteration per cycle on internal registers.

---
 rtl/ex_muldiv_sequencer.sv | 119 +++++++++++
 tb/tb_ex_muldiv_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_sequencer.sv
// Iterative unsigned multiply/divide unit for the EX stage: one shift-add or
// restoring-divide step per cycle, holding the pipeline until the result is ready.
module ex_muldiv_sequencer #(
   parameter int XLEN = 32,
   parameter int ITER = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] data1,
   input  logic [XLEN-1:0] data2,
   input  logic            flush,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(ITER);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state, state_next;
   logic [CW-1:0]   count;
   logic [1:0]      op_q;
   logic [XLEN-1:0] opb;
   logic [XLEN-1:0] lo;
   logic [XLEN-1:0] acc;

   logic            accept, div_zero, last;
   logic [XLEN:0]   sum, shifted, trial;
   logic [XLEN-1:0] acc_next, lo_next, final_val;

   assign accept   = (state == IDLE) && start && !flush;
   assign div_zero = op[1] && (data2 == '0);
   assign last     = (count == CW'(ITER - 1));

   // acc holds the product high word or the partial remainder; lo holds the
   // multiplier being shifted out or the dividend being shifted into quotient bits.
   always_comb begin
      sum     = {1'b0, acc} + (lo[0] ? {1'b0, opb} : '0);
      shifted = {acc, lo[XLEN-1]};
      trial   = shifted - {1'b0, opb};
      if (op_q[1]) begin
         if (trial[XLEN]) begin
            acc_next = shifted[XLEN-1:0];
            lo_next  = {lo[XLEN-2:0], 1'b0};
         end else begin
            acc_next = trial[XLEN-1:0];
            lo_next  = {lo[XLEN-2:0], 1'b1};
         end
      end else begin
         acc_next = sum[XLEN:1];
         lo_next  = {sum[0], lo[XLEN-1:1]};
      end
      final_val = op_q[0] ? acc_next : lo_next;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = div_zero ? DONE : BUSY;
         BUSY: begin
            if (flush)     state_next = IDLE;
            else if (last) state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign stall = accept || (state == BUSY);
   assign busy  = (state != IDLE);
   assign done  = (state == DONE) && !flush;

   // The result register only moves on the edge that enters DONE, so a flush
   // on the final iteration leaves the previous result visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= '0;
         op_q   <= '0;
         opb    <= '0;
         lo     <= '0;
         acc    <= '0;
         result <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q  <= op;
                  count <= '0;
                  acc   <= '0;
                  lo    <= op[1] ? data1 : data2;
                  opb   <= op[1] ? data2 : data1;
                  if (div_zero) result <= op[0] ? data1 : '1;
               end
            end
            BUSY: begin
               if (flush) begin
                  count <= '0;
               end else begin
                  acc   <= acc_next;
                  lo    <= lo_next;
                  count <= count + CW'(1);
                  if (last) result <= final_val;
               end
            end
            default: count <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Self-checking bench for ex_muldiv_sequencer: directed cases with literal
// expectations, then randomized traffic compared every cycle against an arithmetic model.
module tb_ex_muldiv_sequencer;

   logic        clk = 1'b0;
   logic        rst, start, flush;
   logic [1:0]  op;
   logic [31:0] data1, data2;
   logic        stall, busy, done;
   logic [31:0] result;

   int n_checks = 0;
   int n_pass   = 0;

   bit          m_valid     = 1'b0;
   int          m_busy_left = 0;
   bit          m_in_done   = 1'b0;
   logic [31:0] m_result    = '0;
   logic [31:0] m_pending   = '0;

   always #5 clk = ~clk;

   ex_muldiv_sequencer #(.XLEN(32), .ITER(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .data1  (data1),
      .data2  (data2),
      .flush  (flush),
      .stall  (stall),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   function automatic logic [31:0] refResult(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = {32'b0, a} * {32'b0, b};
      case (o)
         2'b00:   return p[31:0];
         2'b01:   return p[63:32];
         2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual === expected) n_pass++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
   endtask

   task automatic applyStimulus(input logic r, input logic s, input logic [1:0] o,
                                input logic [31:0] a, input logic [31:0] b, input logic f);
      @(negedge clk);
      rst   = r;
      start = s;
      op    = o;
      data1 = a;
      data2 = b;
      flush = f;
   endtask

   // Model: an accepted op yields its arithmetic result after 32 busy cycles,
   // or immediately for divide by zero; flush abandons it, reset clears all.
   always @(posedge clk) begin
      if (rst) begin
         m_valid     <= 1'b1;
         m_busy_left <= 0;
         m_in_done   <= 1'b0;
         m_result    <= '0;
      end else if (m_in_done) begin
         m_in_done <= 1'b0;
      end else if (m_busy_left > 0) begin
         if (flush) begin
            m_busy_left <= 0;
         end else begin
            m_busy_left <= m_busy_left - 1;
            if (m_busy_left == 1) begin
               m_in_done <= 1'b1;
               m_result  <= m_pending;
            end
         end
      end else if (start && !flush) begin
         m_pending <= refResult(op, data1, data2);
         if (op[1] && data2 == 0) begin
            m_in_done <= 1'b1;
            m_result  <= refResult(op, data1, data2);
         end else begin
            m_busy_left <= 32;
         end
      end
   end

   always @(negedge clk) begin
      #1;
      if (m_valid) begin
         checkOutput("stall", {31'b0, stall},
                     {31'b0, (m_busy_left > 0) || (m_busy_left == 0 && !m_in_done && start && !flush)});
         checkOutput("busy", {31'b0, busy}, {31'b0, (m_busy_left > 0) || m_in_done});
         checkOutput("done", {31'b0, done}, {31'b0, m_in_done && !flush});
         checkOutput("result", result, m_result);
      end
   end

   task automatic runOp(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
      int lat;
      applyStimulus(1'b0, 1'b1, o, a, b, 1'b0);
      #2 checkOutput({name, " stall at start"}, {31'b0, stall}, 32'd1);
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         applyStimulus(1'b0, 1'b0, o, a, b, 1'b0);
         #2;
         if (done === 1'b1) begin
            lat = k;
            break;
         end
      end
      checkOutput({name, " latency"}, lat, exp_lat);
      checkOutput({name, " result"}, result, exp_res);
      checkOutput({name, " stall at done"}, {31'b0, stall}, 32'd0);
      applyStimulus(1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
   endtask

   initial begin
      bit          saw_done;
      int          lat;
      logic        r, s, f;
      logic [1:0]  o;
      logic [31:0] a, b;

      applyStimulus(1'b1, 1'b0, 2'b00, '0, '0, 1'b0);
      applyStimulus(1'b1, 1'b0, 2'b00, '0, '0, 1'b0);
      applyStimulus(1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
      #2;
      checkOutput("reset busy", {31'b0, busy}, 32'd0);
      checkOutput("reset done", {31'b0, done}, 32'd0);
      checkOutput("reset result", result, 32'd0);

      runOp("MUL 7*6", 2'b00, 32'd7, 32'd6, 32'd42, 33);
      runOp("MULHU max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      runOp("MUL max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
      runOp("DIVU 100/7", 2'b10, 32'd100, 32'd7, 32'd14, 33);
      runOp("REMU 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 33);
      runOp("DIVU by 0", 2'b10, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1);
      runOp("REMU by 0", 2'b11, 32'h1234, 32'd0, 32'h0000_1234, 1);

      // Flush in cycle 10 of a multiply, restart in cycle 12.
      saw_done = 1'b0;
      applyStimulus(1'b0, 1'b1, 2'b00, 32'd9, 32'd9, 1'b0);
      for (int k = 1; k <= 10; k++) begin
         applyStimulus(1'b0, 1'b0, 2'b00, 32'd9, 32'd9, k == 10);
         #2 if (done === 1'b1) saw_done = 1'b1;
      end
      applyStimulus(1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
      #2;
      if (done === 1'b1) saw_done = 1'b1;
      checkOutput("flush no done", {31'b0, saw_done}, 32'd0);
      checkOutput("flush busy", {31'b0, busy}, 32'd0);
      checkOutput("flush result kept", result, 32'h0000_1234);
      runOp("MUL after flush", 2'b00, 32'd9, 32'd9, 32'd81, 33);

      // Reset in cycle 15 of a divide.
      applyStimulus(1'b0, 1'b1, 2'b10, 32'd1000, 32'd3, 1'b0);
      for (int k = 1; k <= 14; k++) applyStimulus(1'b0, 1'b0, 2'b10, 32'd1000, 32'd3, 1'b0);
      applyStimulus(1'b1, 1'b0, 2'b00, '0, '0, 1'b0);
      applyStimulus(1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
      #2;
      checkOutput("rst busy", {31'b0, busy}, 32'd0);
      checkOutput("rst stall", {31'b0, stall}, 32'd0);
      checkOutput("rst result", result, 32'd0);

      // start held high throughout: no re-accept until back in IDLE.
      applyStimulus(1'b0, 1'b1, 2'b00, 32'd3, 32'd5, 1'b0);
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         applyStimulus(1'b0, 1'b1, 2'b00, 32'd3, 32'd5, 1'b0);
         #2;
         if (done === 1'b1) begin
            lat = k;
            break;
         end
      end
      checkOutput("held latency", lat, 32'd33);
      checkOutput("held result", result, 32'd15);
      applyStimulus(1'b0, 1'b1, 2'b00, 32'd3, 32'd5, 1'b0);
      #2;
      checkOutput("held idle busy", {31'b0, busy}, 32'd0);
      checkOutput("held idle stall", {31'b0, stall}, 32'd1);
      applyStimulus(1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
      #2 checkOutput("held reaccept busy", {31'b0, busy}, 32'd1);
      for (int k = 0; k < 40; k++) applyStimulus(1'b0, 1'b0, 2'b00, '0, '0, 1'b0);

      for (int i = 0; i < 3000; i++) begin
         r = ($urandom_range(0, 299) == 0);
         s = ($urandom_range(0, 3) == 0);
         f = ($urandom_range(0, 49) == 0);
         o = 2'($urandom_range(0, 3));
         a = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 1000));
         b = ($urandom_range(0, 7) == 0) ? 32'd0 :
             ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 300)));
         applyStimulus(r, s, o, a, b, f);
      end
      applyStimulus(1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
      applyStimulus(1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
      #2;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
